regfile_wr_arb: RTL and testbench

REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

---
 rtl/regfile_wr_arb.sv | 189 ++++++++++++++++++
 tb/tb_regfile_wr_arb.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arb.sv
// Regfile write-port arbiter: two per-requester FIFOs (ALU, load) feeding one registered write port.
// Define REGFILE_ARB_RR_EN for round-robin grant; otherwise req0 has fixed priority.

module regfile_wr_arb #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_addr,
    input  logic [63:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_addr,
    input  logic [63:0] req1_data,
    output logic        we3,
    output logic [4:0]  wa3,
    output logic [63:0] wd3,
    input  logic [4:0]  chk_addr,
    output logic        chk_hit
);

    localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam logic [4:0]  XZR = 5'd31;

    logic [4:0]       addr_q   [2][DEPTH];
    logic [4:0]       addr_d   [2][DEPTH];
    logic [63:0]      data_q   [2][DEPTH];
    logic [63:0]      data_d   [2][DEPTH];
    logic [DEPTH-1:0] vld_q    [2];
    logic [DEPTH-1:0] vld_d    [2];
    logic [PW-1:0]    wr_ptr_q [2];
    logic [PW-1:0]    wr_ptr_d [2];
    logic [PW-1:0]    rd_ptr_q [2];
    logic [PW-1:0]    rd_ptr_d [2];
    logic [CW-1:0]    cnt_q    [2];
    logic [CW-1:0]    cnt_d    [2];

    logic             we3_q, we3_d;
    logic [4:0]       wa3_q, wa3_d;
    logic [63:0]      wd3_q, wd3_d;

    logic             in_valid [2];
    logic [4:0]       in_addr  [2];
    logic [63:0]      in_data  [2];
    logic             rdy      [2];
    logic             head     [2];
    logic             push     [2];
    logic             pop      [2];
    logic             gnt_sel;
    logic             any_gnt;
    logic [4:0]       gnt_addr;
    logic [63:0]      gnt_data;
    logic             chk_match;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_valid[0] = req0_valid;
    assign in_valid[1] = req1_valid;
    assign in_addr[0]  = req0_addr;
    assign in_addr[1]  = req1_addr;
    assign in_data[0]  = req0_data;
    assign in_data[1]  = req1_data;

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            rdy[i]  = cnt_q[i] < CW'(DEPTH);
            head[i] = cnt_q[i] != '0;
        end
    end

    assign req0_ready = rdy[0];
    assign req1_ready = rdy[1];
    assign any_gnt    = head[0] | head[1];

`ifdef REGFILE_ARB_RR_EN
    // rr_q set means req1 owns the next contended grant
    logic rr_q, rr_d;

    assign gnt_sel = (head[0] && head[1]) ? rr_q : head[1];

    always_comb begin
        rr_d = rr_q;
        if (any_gnt) begin
            rr_d = ~gnt_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    assign gnt_sel = ~head[0];
`endif

    assign gnt_addr = addr_q[gnt_sel][rd_ptr_q[gnt_sel]];
    assign gnt_data = data_q[gnt_sel][rd_ptr_q[gnt_sel]];

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            pop[i]  = any_gnt && (gnt_sel == 1'(i));
            push[i] = in_valid[i] && rdy[i];
        end
    end

    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        for (int unsigned i = 0; i < 2; i++) begin
            if (pop[i]) begin
                vld_d[i][rd_ptr_q[i]] = 1'b0;
                rd_ptr_d[i]           = ptr_inc(rd_ptr_q[i]);
            end
            // a full queue never pushes, so push and pop never target the same slot
            if (push[i]) begin
                addr_d[i][wr_ptr_q[i]] = in_addr[i];
                data_d[i][wr_ptr_q[i]] = in_data[i];
                vld_d[i][wr_ptr_q[i]]  = 1'b1;
                wr_ptr_d[i]            = ptr_inc(wr_ptr_q[i]);
            end
            cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
        end
    end

    // XZR grants still pop but leave the write port idle and its address/data untouched
    always_comb begin
        we3_d = 1'b0;
        wa3_d = wa3_q;
        wd3_d = wd3_q;
        if (any_gnt && (gnt_addr != XZR)) begin
            we3_d = 1'b1;
            wa3_d = gnt_addr;
            wd3_d = gnt_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '{default: '0};
            data_q   <= '{default: '0};
            vld_q    <= '{default: '0};
            wr_ptr_q <= '{default: '0};
            rd_ptr_q <= '{default: '0};
            cnt_q    <= '{default: '0};
            we3_q    <= 1'b0;
            wa3_q    <= '0;
            wd3_q    <= '0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            we3_q    <= we3_d;
            wa3_q    <= wa3_d;
            wd3_q    <= wd3_d;
        end
    end

    always_comb begin
        chk_match = we3_q && (wa3_q == chk_addr);
        for (int unsigned i = 0; i < 2; i++) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (vld_q[i][j] && (addr_q[i][j] == chk_addr)) begin
                    chk_match = 1'b1;
                end
            end
        end
    end

    assign chk_hit = chk_match && (chk_addr != XZR);
    assign we3     = we3_q;
    assign wa3     = wa3_q;
    assign wd3     = wd3_q;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Self-checking bench for regfile_wr_arb: directed vector table, then a cycle-level model with a write scoreboard.
// Honours REGFILE_ARB_RR_EN the same way as the design.

module tb_regfile_wr_arb;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_addr, req1_addr;
    logic [63:0] req0_data, req1_data;
    logic        we3;
    logic [4:0]  wa3;
    logic [63:0] wd3;
    logic [4:0]  chk_addr;
    logic        chk_hit;

    always #5 clk = ~clk;

    regfile_wr_arb #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .we3        (we3),
        .wa3        (wa3),
        .wd3        (wd3),
        .chk_addr   (chk_addr),
        .chk_hit    (chk_hit)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [63:0] data;
    } ent_t;

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [63:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [63:0] d1;
        logic [4:0]  chk;
        logic        rdy0;
        logic        rdy1;
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic        hit;
    } vec_t;

    vec_t        vecs[14];
    int          checks = 0;
    int          errors = 0;
    ent_t        mq0[$];
    ent_t        mq1[$];
    ent_t        sb[$];
    logic        pref1;
    logic        m_we;
    logic [4:0]  m_wa;
    logic [63:0] m_wd;
    int          n_wr;
    int          n_wr1;

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [63:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [63:0] d1,
                         input logic [4:0] c);
        req0_valid = v0;
        req0_addr  = a0;
        req0_data  = d0;
        req1_valid = v1;
        req1_addr  = a1;
        req1_data  = d1;
        chk_addr   = c;
    endtask

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        sb.delete();
        pref1 = 1'b0;
        m_we  = 1'b0;
        m_wa  = '0;
        m_wd  = '0;
    endtask

    // Called at a negedge with inputs already driven; advances one clock and checks outputs.
    task automatic sb_cycle(output logic acc0);
        logic acc1;
        logic g;
        logic exp_hit;
        ent_t e;
        ent_t n;
        chk_eq("req0_ready", req0_ready, mq0.size() < DEPTH);
        chk_eq("req1_ready", req1_ready, mq1.size() < DEPTH);
        acc0 = req0_valid && (mq0.size() < DEPTH);
        acc1 = req1_valid && (mq1.size() < DEPTH);
        @(posedge clk);
        m_we = 1'b0;
        if (mq0.size() != 0 || mq1.size() != 0) begin
            if (mq0.size() != 0 && mq1.size() != 0) begin
`ifdef REGFILE_ARB_RR_EN
                g = pref1;
`else
                g = 1'b0;
`endif
            end else begin
                g = (mq0.size() == 0);
            end
            if (g) e = mq1.pop_front();
            else   e = mq0.pop_front();
            pref1 = ~g;
            if (e.addr != 5'd31) begin
                m_we = 1'b1;
                m_wa = e.addr;
                m_wd = e.data;
                sb.push_back(e);
            end
        end
        if (acc0) begin
            n.addr = req0_addr;
            n.data = req0_data;
            mq0.push_back(n);
        end
        if (acc1) begin
            n.addr = req1_addr;
            n.data = req1_data;
            mq1.push_back(n);
        end
        @(negedge clk);
        chk_eq("we3", we3, m_we);
        if (we3 === 1'b1) begin
            n_wr++;
            if (wd3[11:8] == 4'h2) n_wr1++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: write wa3=%0d wd3=0x%0h, expected none", wa3, wd3);
            end else begin
                e = sb.pop_front();
                chk_eq("wa3", wa3, e.addr);
                chk_eq("wd3", wd3, e.data);
            end
        end else begin
            if (sb.size() != 0) e = sb.pop_front();
            chk_eq("wa3_hold", wa3, m_wa);
            chk_eq("wd3_hold", wd3, m_wd);
        end
        exp_hit = m_we && (m_wa == chk_addr);
        foreach (mq0[k]) if (mq0[k].addr == chk_addr) exp_hit = 1'b1;
        foreach (mq1[k]) if (mq1[k].addr == chk_addr) exp_hit = 1'b1;
        if (chk_addr == 5'd31) exp_hit = 1'b0;
        chk_eq("chk_hit", chk_hit, exp_hit);
    endtask

    task automatic idle_cycles(input int n, input logic [4:0] c);
        logic a;
        for (int k = 0; k < n; k++) begin
            drive(1'b0, '0, '0, 1'b0, '0, '0, c);
            sb_cycle(a);
        end
    endtask

    initial begin
        logic acc;
        int   i;

        //        v0    a0     d0         v1    a1      d1        chk    rdy0  rdy1  we    wa     wd         hit
        vecs[0]  = '{1'b1, 5'd5, 64'h1234, 1'b0, 5'd0,  64'h0,  5'd5,  1'b1, 1'b1, 1'b0, 5'd0, 64'h0,    1'b1};
        vecs[1]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0,  64'h0,  5'd5,  1'b1, 1'b1, 1'b1, 5'd5, 64'h1234, 1'b1};
        vecs[2]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0,  64'h0,  5'd5,  1'b1, 1'b1, 1'b0, 5'd5, 64'h1234, 1'b0};
        vecs[3]  = '{1'b0, 5'd0, 64'h0,    1'b1, 5'd31, 64'hFF, 5'd31, 1'b1, 1'b1, 1'b0, 5'd5, 64'h1234, 1'b0};
        vecs[4]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0,  64'h0,  5'd31, 1'b1, 1'b1, 1'b0, 5'd5, 64'h1234, 1'b0};
        vecs[5]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0,  64'h0,  5'd7,  1'b1, 1'b1, 1'b0, 5'd5, 64'h1234, 1'b0};
        vecs[6]  = '{1'b1, 5'd7, 64'h77,   1'b0, 5'd0,  64'h0,  5'd7,  1'b1, 1'b1, 1'b0, 5'd5, 64'h1234, 1'b1};
        vecs[7]  = '{1'b0, 5'd0, 64'h0,    1'b1, 5'd8,  64'h88, 5'd8,  1'b1, 1'b1, 1'b1, 5'd7, 64'h77,   1'b1};
        vecs[8]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0,  64'h0,  5'd7,  1'b1, 1'b1, 1'b1, 5'd8, 64'h88,   1'b0};
        vecs[9]  = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0,  64'h0,  5'd8,  1'b1, 1'b1, 1'b0, 5'd8, 64'h88,   1'b0};
        vecs[10] = '{1'b1, 5'd3, 64'hA,    1'b1, 5'd3,  64'hB,  5'd3,  1'b1, 1'b1, 1'b0, 5'd8, 64'h88,   1'b1};
        vecs[11] = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0,  64'h0,  5'd3,  1'b1, 1'b1, 1'b1, 5'd3, 64'hA,    1'b1};
        vecs[12] = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0,  64'h0,  5'd3,  1'b1, 1'b1, 1'b1, 5'd3, 64'hB,    1'b1};
        vecs[13] = '{1'b0, 5'd0, 64'h0,    1'b0, 5'd0,  64'h0,  5'd3,  1'b1, 1'b1, 1'b0, 5'd3, 64'hB,    1'b0};

        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0, 5'd5);
        @(negedge clk);
        chk_eq("rst_we3", we3, 1'b0);
        chk_eq("rst_wa3", wa3, 5'd0);
        chk_eq("rst_wd3", wd3, 64'h0);
        chk_eq("rst_ready0", req0_ready, 1'b1);
        chk_eq("rst_ready1", req1_ready, 1'b1);
        chk_eq("rst_chk_hit", chk_hit, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            drive(vecs[k].v0, vecs[k].a0, vecs[k].d0, vecs[k].v1, vecs[k].a1, vecs[k].d1, vecs[k].chk);
            chk_eq($sformatf("tbl%0d_ready0", k), req0_ready, vecs[k].rdy0);
            chk_eq($sformatf("tbl%0d_ready1", k), req1_ready, vecs[k].rdy1);
            @(posedge clk);
            @(negedge clk);
            chk_eq($sformatf("tbl%0d_we3", k), we3, vecs[k].we);
            chk_eq($sformatf("tbl%0d_wa3", k), wa3, vecs[k].wa);
            chk_eq($sformatf("tbl%0d_wd3", k), wd3, vecs[k].wd);
            chk_eq($sformatf("tbl%0d_chk_hit", k), chk_hit, vecs[k].hit);
        end

        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, '0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Both requesters saturated: fixed priority starves req1, round-robin alternates.
        n_wr1 = 0;
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 5'(k), 64'h100 + 64'(k), 1'b1, 5'(k + 16), 64'h200 + 64'(k), 5'($urandom_range(0, 31)));
            sb_cycle(acc);
        end
`ifdef REGFILE_ARB_RR_EN
        chk_eq("rr_req1_grants", n_wr1 >= 4, 1'b1);
`else
        chk_eq("fixed_req1_starved", n_wr1, 0);
`endif
        idle_cycles(8, 5'd20);

        // Stream 20 in-order writes through queue 0 across several pointer wraps.
        n_wr = 0;
        i = 0;
        for (int c = 0; c < 60 && i < 20; c++) begin
            drive(1'b1, 5'(i % 31), 64'(i), 1'b0, '0, '0, 5'($urandom_range(0, 31)));
            sb_cycle(acc);
            if (acc) i++;
        end
        idle_cycles(4, 5'd0);
        chk_eq("wrap_writes", n_wr, 20);

        for (int k = 0; k < 150; k++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom},
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), {$urandom, $urandom},
                  5'($urandom_range(0, 31)));
            sb_cycle(acc);
        end
        idle_cycles(8, 5'd9);

        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 5'd12, 64'hC0 + 64'(k), 1'b1, 5'd13, 64'hD0 + 64'(k), 5'd12);
            sb_cycle(acc);
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0, 5'd12);
        rst_n = 1'b0;
        #1;
        chk_eq("midrst_we3", we3, 1'b0);
        chk_eq("midrst_wa3", wa3, 5'd0);
        chk_eq("midrst_wd3", wd3, 64'h0);
        chk_eq("midrst_ready0", req0_ready, 1'b1);
        chk_eq("midrst_ready1", req1_ready, 1'b1);
        chk_eq("midrst_chk_hit", chk_hit, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk_eq("midrst_hold_we3", we3, 1'b0);
        rst_n = 1'b1;
        model_reset();
        idle_cycles(3, 5'd12);
        idle_cycles(2, 5'd13);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
